// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dram_responder
// Brief    : Byte-wide DRAM target with fixed access latency, valid/ready
//            request and read-response handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module dram_responder #(
    parameter int DEPTH   = 4096,
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cache_vld,
    input  logic        dram_is_rd,
    input  logic [31:0] dram_op_address,
    input  logic [7:0]  dram_store,
    output logic        dram_rdy,
    output logic        dram_vld,
    output logic [7:0]  dram_load,
    input  logic        cache_rdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] c_cnt_init = 8'(LATENCY - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_is_rd;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_wdata;
    logic [7:0]          r_cnt;
    logic [7:0]          r_load;
    logic [7:0]          r_mem [DEPTH];

    logic                w_accept;
    logic                w_done;

    assign dram_rdy  = (r_state == IDLE);
    assign dram_vld  = (r_state == RESP);
    assign dram_load = r_load;

    assign w_accept = (r_state == IDLE) && cache_vld;
    assign w_done   = (r_state == BUSY) && (r_cnt == 8'd0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (cache_vld) w_next = BUSY;
            BUSY:    if (r_cnt == 8'd0) w_next = r_is_rd ? RESP : IDLE;
            RESP:    if (cache_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_is_rd <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 8'd0;
            r_cnt   <= 8'd0;
            r_load  <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_rd <= dram_is_rd;
                r_addr  <= dram_op_address[ADDR_W-1:0];
                r_wdata <= dram_store;
                r_cnt   <= c_cnt_init;
            end else if (r_state == BUSY && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_done && r_is_rd) begin
                r_load <= r_mem[r_addr];
            end
        end
    end

    // Storage survives reset; a write caught by reset on its commit edge is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && w_done && !r_is_rd) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule
`default_nettype wire
